// File: rtl/accel_pkg.sv
// Shared types for the accelerator arbiter: FSM encoding, datapath and counter widths.
// Pure declarations, no logic.
// No flow control.
package accel_pkg;

    localparam int ACC_DATA_W = 1024;
    localparam int CNT_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/accel_arbiter_rr_picker.sv
// Round-robin select: lowest requester at or above ptr, else lowest overall (wrap).
// Combinational, zero latency.
// No backpressure; caller samples sel_o when any_o is high.
module rr_picker
    import accel_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] sel_o,
    output logic          any_o
);

    // Second pass overrides the wrap candidate whenever something sits at/above ptr.
    always_comb begin
        sel_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) sel_o = IW'(i);
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i] && (IW'(i) >= ptr_i)) sel_o = IW'(i);
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/accel_arbiter.sv
// Shares one accelerator core between N_REQ requesters, one operation at a time, round-robin.
// Latency req->rsp_valid is 4 cycles with a 2-cycle core; one operation per 5 cycles at best.
// Requests are levels held until rsp_valid; ACCEL_ARB_TIMEOUT_EN bounds the WAIT state.
module accel_arbiter
    import accel_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int DATA_W  = ACC_DATA_W,
    parameter int MIN_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_din,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_dout,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      acc_start,
    output logic [DATA_W-1:0]         acc_din,
    input  logic [DATA_W-1:0]         acc_dout,
    input  logic                      acc_done
);

    localparam int IW = $clog2(N_REQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d, sel_q, sel_d, pick;
    logic              any_req;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0] rsp_dout_q, rsp_dout_d, acc_din_q, acc_din_d, op_sel;
    logic              done_ok;

    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .sel_o (pick),
        .any_o (any_req)
    );

    assign op_sel  = req_din[int'(sel_q) * DATA_W +: DATA_W];
    // Saturate so a long wait can never wrap back under MIN_LAT.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    assign done_ok = acc_done && (cnt_inc >= CNT_W'(MIN_LAT));

`ifdef ACCEL_ARB_TIMEOUT_EN
    logic rsp_err_q, rsp_err_d;
    assign rsp_err = rsp_err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign rsp_err        = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        cnt_d      = cnt_q;
        rsp_dout_d = rsp_dout_q;
        acc_din_d  = acc_din_q;
`ifdef ACCEL_ARB_TIMEOUT_EN
        rsp_err_d  = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    sel_d   = pick;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                acc_din_d = op_sel;
                cnt_d     = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (done_ok) begin
                    rsp_dout_d = acc_dout;
`ifdef ACCEL_ARB_TIMEOUT_EN
                    rsp_err_d  = 1'b0;
`endif
                    state_d    = ST_RESP;
                end
`ifdef ACCEL_ARB_TIMEOUT_EN
                else if (cnt_inc >= CNT_W'(TIMEOUT)) begin
                    rsp_dout_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                ptr_d   = (sel_q == IW'(N_REQ - 1)) ? '0 : sel_q + IW'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            sel_q      <= '0;
            cnt_q      <= '0;
            rsp_dout_q <= '0;
            acc_din_q  <= '0;
`ifdef ACCEL_ARB_TIMEOUT_EN
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            cnt_q      <= cnt_d;
            rsp_dout_q <= rsp_dout_d;
            acc_din_q  <= acc_din_d;
`ifdef ACCEL_ARB_TIMEOUT_EN
            rsp_err_q  <= rsp_err_d;
`endif
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign acc_start = (state_q == ST_ISSUE);
    assign gnt       = (state_q == ST_ISSUE) ? (N_REQ'(1) << sel_q) : '0;
    assign rsp_valid = (state_q == ST_RESP)  ? (N_REQ'(1) << sel_q) : '0;
    assign rsp_dout  = rsp_dout_q;
    // Operand comes straight from the registered winner while issuing, then holds.
    assign acc_din   = (state_q == ST_ISSUE) ? op_sel : acc_din_q;

endmodule

// File: tb/tb_accel_arbiter.sv
// Directed bench for accel_arbiter with a behavioural 2-cycle accelerator whose done is a held level.
module tb_accel_arbiter;

    localparam int DW = 1024;
`ifdef ACCEL_ARB_TIMEOUT_EN
    localparam int TB_TO = 8;
`else
    localparam int TB_TO = 255;
`endif

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic [1:0]      req = 2'b00;
    logic [2*DW-1:0] req_din = '0;
    logic [1:0]      gnt, rsp_valid;
    logic [DW-1:0]   rsp_dout, acc_din, acc_dout;
    logic            rsp_err, busy, acc_start, acc_done;

    logic            m_s1, m_done, kill = 1'b0;
    logic [DW-1:0]   m_din, m_dout;
    logic [DW-1:0]   op1, opa, op5, op3;

    int n_chk = 0;
    int n_bad = 0;
    int cyc;
    int cnt;

    accel_arbiter #(.N_REQ(2), .DATA_W(DW), .MIN_LAT(2), .TIMEOUT(TB_TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .req_din   (req_din),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .acc_start (acc_start),
        .acc_din   (acc_din),
        .acc_dout  (acc_dout),
        .acc_done  (acc_done)
    );

    always #5 clk = ~clk;

    // Accelerator: result two edges after start; done stays high until reset.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_s1   <= 1'b0;
            m_done <= 1'b0;
            m_din  <= '0;
            m_dout <= '0;
        end else begin
            m_s1 <= acc_start;
            if (acc_start) m_din <= acc_din;
            if (m_s1) begin
                m_done <= 1'b1;
                m_dout <= {32'hDEADBEEF, m_din[DW-33:0]};
            end
        end
    end
    assign acc_done = m_done & ~kill;
    assign acc_dout = m_dout;

    function automatic logic [DW-1:0] xp(input logic [DW-1:0] op);
        return {32'hDEADBEEF, op[DW-33:0]};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h..%h exp=%h..%h", tag,
                     got[DW-1:DW-64], got[63:0], exp[DW-1:DW-64], exp[63:0]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int bound, output int c);
        c = -1;
        for (int n = 1; n <= bound; n++) begin
            step();
            if (rsp_valid != 2'b00) begin
                c = n;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        op1 = {32{32'h11111111}};
        opa = {128{8'hAA}};
        op5 = {128{8'h55}};
        op3 = {32{32'h33333333}};

        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_rspv", rsp_valid, 0);
        chk("rst_dout", rsp_dout, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", acc_start, 0);
        chk("rst_din", acc_din, 0);
        step();
        resetn = 1'b1;

        // Contention, then requester 1 runs against a stale done level.
        req = 2'b11;
        req_din = {op5, opa};
        step();
        chk("c_gnt0", gnt, 2'b01);
        chk("c_start", acc_start, 1);
        chk("c_din0", acc_din, opa);
        chk("c_busy", busy, 1);
        step();
        chk("c_start_off", acc_start, 0);
        chk("c_rspv_t2", rsp_valid, 0);
        step();
        chk("c_rspv_t3", rsp_valid, 0);
        step();
        chk("c_rspv0", rsp_valid, 2'b01);
        chk("c_dout0", rsp_dout, xp(opa));
        chk("c_err0", rsp_err, 0);
        req = 2'b10;
        step();
        chk("c_idle", busy, 0);
        chk("c_din_hold", acc_din, opa);
        step();
        chk("c_gnt1", gnt, 2'b10);
        chk("c_din1", acc_din, op5);
        step();
        step();
        chk("stale_none", rsp_valid, 0);
        step();
        chk("stale_rspv", rsp_valid, 2'b10);
        chk("stale_dout", rsp_dout, xp(op5));
        req = 2'b00;
        step();

        // Fairness: requester 0 holds req, requester 1 joins mid-operation.
        req = 2'b01;
        req_din = {op3, op1};
        step();
        chk("f_gnt0", gnt, 2'b01);
        step();
        req = 2'b11;
        step();
        step();
        chk("f_rspv0", rsp_valid, 2'b01);
        chk("f_dout0", rsp_dout, xp(op1));
        step();
        step();
        chk("f_gnt1", gnt, 2'b10);
        step();
        step();
        step();
        chk("f_rspv1", rsp_valid, 2'b10);
        chk("f_dout1", rsp_dout, xp(op3));
        req = 2'b01;
        step();
        step();
        chk("f_gnt0_again", gnt, 2'b01);
        wait_rsp(8, cyc);
        chk("f_lat", cyc, 3);
        req = 2'b00;
        step();

        // Reset during the first WAIT cycle.
        req = 2'b01;
        req_din = {op3, opa};
        step();
        step();
        resetn = 1'b0;
        #1;
        chk("r_busy", busy, 0);
        chk("r_gnt", gnt, 0);
        chk("r_start", acc_start, 0);
        chk("r_din", acc_din, 0);
        chk("r_dout", rsp_dout, 0);
        chk("r_rspv", rsp_valid, 0);
        req = 2'b00;
        step();
        resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (rsp_valid != 2'b00) cnt++;
        end
        chk("r_no_rsp", cnt, 0);
        req = 2'b10;
        wait_rsp(10, cyc);
        chk("r_lat", cyc, 4);
        chk("r_rspv", rsp_valid, 2'b10);
        chk("r_new_dout", rsp_dout, xp(op3));
        req = 2'b00;
        step();

`ifdef ACCEL_ARB_TIMEOUT_EN
        // Timeout with done held low.
        kill = 1'b1;
        req = 2'b10;
        req_din = {op5, op1};
        wait_rsp(20, cyc);
        chk("to_lat", cyc, 10);
        chk("to_rspv", rsp_valid, 2'b10);
        chk("to_err", rsp_err, 1);
        chk("to_dout", rsp_dout, 0);
        req = 2'b00;
        kill = 1'b0;
        step();
`else
        // Done withheld until WAIT cycle 512: a saturating counter accepts it at once.
        kill = 1'b1;
        req = 2'b01;
        req_din = {op5, op1};
        step();
        chk("sat_gnt", gnt, 2'b01);
        repeat (512) step();
        chk("sat_busy", busy, 1);
        kill = 1'b0;
        wait_rsp(10, cyc);
        chk("sat_lat", cyc, 1);
        chk("sat_rspv", rsp_valid, 2'b01);
        chk("sat_dout", rsp_dout, xp(op1));
        chk("sat_err", rsp_err, 0);
        req = 2'b00;
        step();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
